// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receive and transmit blocks.
//   rx_state_e : receiver frame states
//   DATA_BITS  : payload bits per frame (8N1)
//   clamp_div  : lower-bounds a baud divisor to 2 cycles per bit so the
//                half-bit centring count is never zero
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous first-word-fall-through FIFO holding received bytes.
//   clk_i, rst_i : clock, synchronous active-high reset (flushes pointers)
//   push, din    : write din when not full, or when full and popping this cycle
//   pop          : advance the head; ignored while empty
//   dout         : current head, forced to 0 while empty
//   empty, full  : occupancy flags
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  // The storage array is not reset, so mask the head to keep dout defined.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the data array has no reset; only the pointers define validity,
  // which lets synthesis map it onto plain RAM or reset-less flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a receive FIFO. The serial line is synchronised,
// a falling edge starts a frame, each bit is sampled near its centre using a
// down-counter reloaded from the captured divisor, and completed bytes are
// pushed into a first-word-fall-through FIFO.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   baud_div_i   : clk_i cycles per bit, captured when a start edge is seen
//   rx_en_i      : receiver enable; low abandons any frame in progress
//   rx_bit_i     : asynchronous serial input, idle high
//   rx_ren_i     : pop FIFO head
//   dout_o       : FIFO head (valid while empty_o = 0)
//   empty_o      : FIFO empty
//   full_o       : FIFO full
//   frame_err_o  : one-cycle pulse, stop bit sampled low (byte dropped)
//   overrun_o    : one-cycle pulse, byte completed while FIFO full (dropped)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] baud_div_i,
  input  logic        rx_en_i,
  input  logic        rx_bit_i,
  input  logic        rx_ren_i,
  output logic [7:0]  dout_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  localparam int BW = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [1:0]             state_q;
  logic [15:0]            div_q;
  logic [15:0]            cnt_q;
  logic [15:0]            div_in;
  logic [BW-1:0]          bitcnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   tick;
  logic                   push_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  // Line synchroniser; resets to the idle (high) level so reset never looks
  // like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_bit_i};
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign div_in = clamp_div(baud_div_i);
  assign tick   = (cnt_q == '0);

  // Frame FSM. Every state counts cnt_q down and acts when it reaches zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle and are only set on the event
      // cycle, which guarantees a width of exactly one clock.
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (!rx_en_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s) begin
              state_q  <= S_START;
              div_q    <= div_in;
              cnt_q    <= div_in >> 1;   // half a bit to reach the start-bit centre
              bitcnt_q <= '0;
            end
          end
          S_START: begin
            if (!tick) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (!rx_s) begin
              state_q <= S_DATA;
              cnt_q   <= div_q - 1'b1;
            end else begin
              state_q <= S_IDLE;         // line back high at centre: glitch
            end
          end
          S_DATA: begin
            if (!tick) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              shreg_q  <= {rx_s, shreg_q[DATA_BITS-1:1]};   // LSB first
              bitcnt_q <= bitcnt_q + 1'b1;
              cnt_q    <= div_q - 1'b1;
              if (bitcnt_q == BW'(DATA_BITS - 1)) state_q <= S_STOP;
            end
          end
          S_STOP: begin
            if (!tick) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              // Leave at the stop-bit centre so a following start edge is seen
              // immediately.
              if (rx_s) push_q      <= 1'b1;
              else      frame_err_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // The push is registered, so the overrun decision is made on the cycle the
  // FIFO would accept it; a simultaneous pop frees the slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) overrun_q <= 1'b0;
    else       overrun_q <= push_q && full_o && !rx_ren_i;
  end

  // shreg_q is stable until the next frame's first data sample, well after
  // the registered push, so it can feed the FIFO directly.
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_q),
    .pop   (rx_ren_i),
    .din   (shreg_q),
    .dout  (dout_o),
    .empty (empty_o),
    .full  (full_o)
  );

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Bit-banged serial stimulus against uart_rx (FIFO_DEPTH = 4), with a byte
// scoreboard: expected bytes are queued as frames are sent and compared as
// they are popped from the FIFO head. Error pulses are counted on every
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] baud_div_i;
  logic        rx_en_i;
  logic        rx_bit_i;
  logic        rx_ren_i;
  logic [7:0]  dout_o;
  logic        empty_o;
  logic        full_o;
  logic        frame_err_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int start_cyc = 0;
  int fall_cyc = -1;
  logic prev_empty = 1'b1;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  int fe0, ov0;

  uart_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .baud_div_i  (baud_div_i),
    .rx_en_i     (rx_en_i),
    .rx_bit_i    (rx_bit_i),
    .rx_ren_i    (rx_ren_i),
    .dout_o      (dout_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err_o === 1'b1) fe_cnt++;
    if (overrun_o === 1'b1)   ov_cnt++;
    if (prev_empty === 1'b1 && empty_o === 1'b0) fall_cyc = cyc;
    prev_empty = empty_o;
  end

  // Drives the first n_bits of a frame (start, 8 data LSB first, stop), each
  // held div clocks. If pop_at >= 0, rx_ren_i is pulsed for the clock edge
  // following the pop_at-th driven cycle of the frame.
  task automatic send_frame(input logic [7:0] data, input int div,
                            input logic stop_val, input int n_bits,
                            input int pop_at);
    logic [9:0] bits;
    int idx;
    bits = {stop_val, data, 1'b0};
    baud_div_i = 16'(div);
    idx = 0;
    for (int b = 0; b < n_bits; b++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        rx_bit_i = bits[b];
        rx_ren_i = (idx == pop_at);
        if (idx == 0) start_cyc = cyc;
        idx++;
      end
    end
  endtask

  task automatic pulse_ren();
    @(negedge clk);
    rx_ren_i = 1'b1;
    @(negedge clk);
    rx_ren_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rx_en_i = 1'b1; rx_bit_i = 1'b1; rx_ren_i = 1'b0;
    baud_div_i = 16'd16;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
    checks++; if (dout_o !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout_o); end
    checks++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got fe=%b ov=%b exp 0 0", frame_err_o, overrun_o);
    end
  endtask

  task automatic test_single();
    int lat;
    fall_cyc = -1;
    send_frame(8'hA5, 104, 1'b1, 10, -1);
    exp_q.push_back(8'hA5);
    repeat (4) @(negedge clk);
    // Start edge to byte visible: ~9.5 bits + synchroniser + registered push.
    lat = fall_cyc - start_cyc;
    checks++; if (fall_cyc < 0 || lat < 988 || lat > 994) begin
      errors++; $display("FAIL single_latency got=%0d exp=991+-3", lat);
    end
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL single_data got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(vals[i], 16, 1'b1, 10, -1);
      exp_q.push_back(vals[i]);
    end
    repeat (5) @(negedge clk);
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL b2b_pulses got fe=%0d ov=%0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL b2b_full got=%b exp=0", full_o); end
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL b2b_data got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL b2b_drained got=%b exp=1", empty_o); end
  endtask

  task automatic test_glitch();
    fe0 = fe_cnt; ov0 = ov_cnt;
    baud_div_i = 16'd16;
    @(negedge clk); rx_bit_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_bit_i = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (empty_o !== 1'b1 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL glitch_ignored got empty=%b fe=%0d ov=%0d exp 1 0 0", empty_o, fe_cnt - fe0, ov_cnt - ov0);
    end
    send_frame(8'h96, 16, 1'b1, 10, -1);
    exp_q.push_back(8'h96);
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL glitch_next got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end
  endtask

  task automatic test_frame_err();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 16, 1'b0, 10, -1);
    @(negedge clk); rx_bit_i = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (empty_o !== 1'b1 || ov_cnt != ov0) begin
      errors++; $display("FAIL ferr_dropped got empty=%b ov=%0d exp 1 0", empty_o, ov_cnt - ov0);
    end
    send_frame(8'h12, 16, 1'b1, 10, -1);
    exp_q.push_back(8'h12);
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL ferr_next got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_once got=%0d exp=1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    // Without reads: five bytes into four slots, the fifth is dropped.
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 16, 1'b1, 10, -1);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    repeat (5) @(negedge clk);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovr_full got=%b exp=1", full_o); end
    checks++; if (ov_cnt - ov0 != 1 || fe_cnt != fe0) begin
      errors++; $display("FAIL ovr_pulse got ov=%0d fe=%0d exp 1 0", ov_cnt - ov0, fe_cnt - fe0);
    end
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL ovr_data got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ovr_drained got=%b exp=1", empty_o); end

    // With a pop on the fifth push cycle: no overrun, FIFO stays full.
    // Push edge after start: SYNC + 1 detect + div/2 + 1 + 9*div (stop sample)
    // + 1 registered push = 157 for div = 16, i.e. driven cycle 156.
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'h10 + 8'(i), 16, 1'b1, 10, -1);
      exp_q.push_back(8'h10 + 8'(i));
    end
    send_frame(8'h15, 16, 1'b1, 10, SYNC + 2 + 8 + 9 * 16);
    rx_ren_i = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h15);
    repeat (5) @(negedge clk);
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL ovr_pop_none got=%0d exp=0", ov_cnt - ov0); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovr_pop_full got=%b exp=1", full_o); end
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL ovr_pop_data got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end
  endtask

  task automatic test_abort();
    // Reset after 4 data bits of 0xC3: partial byte and queued byte discarded.
    send_frame(8'h33, 16, 1'b1, 10, -1);
    repeat (3) @(negedge clk);
    send_frame(8'hC3, 16, 1'b1, 5, -1);
    @(negedge clk); rst_i = 1'b1; rx_bit_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (200) @(negedge clk);
    checks++; if (empty_o !== 1'b1 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL abort_rst got empty=%b fe=%0d ov=%0d exp 1 0 0", empty_o, fe_cnt - fe0, ov_cnt - ov0);
    end
    send_frame(8'h7E, 16, 1'b1, 10, -1);
    exp_q.push_back(8'h7E);
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL abort_rst_next got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end

    // Disable after 4 data bits: nothing pushed, queued byte stays readable.
    send_frame(8'h44, 16, 1'b1, 10, -1);
    exp_q.push_back(8'h44);
    repeat (3) @(negedge clk);
    send_frame(8'hC3, 16, 1'b1, 5, -1);
    @(negedge clk); rx_en_i = 1'b0; rx_bit_i = 1'b1;
    repeat (2) @(negedge clk);
    rx_en_i = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (200) @(negedge clk);
    checks++; if (empty_o !== 1'b0 || dout_o !== 8'h44 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL abort_en got dout=%h empty=%b fe=%0d ov=%0d exp 44 0 0 0",
                         dout_o, empty_o, fe_cnt - fe0, ov_cnt - ov0);
    end
    send_frame(8'h7E, 16, 1'b1, 10, -1);
    exp_q.push_back(8'h7E);
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (empty_o !== 1'b0 || dout_o !== exp_b) begin
        errors++; $display("FAIL abort_en_data got=%h empty=%b exp=%h", dout_o, empty_o, exp_b);
      end
      pulse_ren();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL abort_drained got=%b exp=1", empty_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
